// File: rtl/vram_arb_pkg.sv
// Shared types and helpers for the VRAM port arbiter.
// Also used by other shared-resource arbiters.
package vram_arb_pkg;

  localparam int CONSEC_W = 4;

  typedef struct packed {
    logic       rd;
    logic [2:0] id;
  } tag_t;

  // One-hot round-robin pick over bits 1..7, first hit at or after ptr.
  // Bit 0 is never picked; unused upper bits must be zero.
  function automatic logic [7:0] rr_pick(
    input logic [7:0] valid,
    input logic [2:0] ptr
  );
    logic [7:0] pick;
    logic [2:0] idx;
    int         p;
    pick = '0;
    p    = (ptr == 3'd0) ? 1 : int'(ptr);
    for (int i = 0; i < 7; i++) begin
      idx = 3'(((p - 1 + i) % 7) + 1);
      if (pick == '0 && valid[idx]) begin
        pick[idx] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester-side bus of the VRAM arbiter.
// master = requesters, slave = arbiter.
interface vram_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 8
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/rr_select.sv
// Combinational round-robin one-hot picker.
// Considers requesters 1..N-1 only; bit 0 never wins.
module rr_select
  import vram_arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] valid,
  input  logic [2:0]   ptr,
  output logic [N-1:0] grant
);

  logic [7:0] v8;
  logic [7:0] p8;
  logic       unused_bits;

  // Widen to the helper's fixed 8-bit view with bit 0 masked.
  always_comb begin
    v8          = '0;
    v8[N-1:1]   = valid[N-1:1];
  end

  assign p8          = rr_pick(v8, ptr);
  assign grant       = p8[N-1:0];
  assign unused_bits = ^{p8, valid[0]};

endmodule

// File: rtl/vram_arbiter.sv
// Shares one VRAM port among NUM_REQ requesters.
// Requester 0 has bounded priority; reads return tagged.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 8,
  parameter int MAX_CONSEC = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  vram_arbiter_if.slave     bus,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [CONSEC_W-1:0] MAXC =
    CONSEC_W'(MAX_CONSEC);

  logic [CONSEC_W-1:0] consec_cnt;
  logic [2:0]          rr_ptr;
  logic [2:0]          ptr_nxt;
  logic [NUM_REQ-1:0]  rr_grant;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  rsp;
  logic                others;
  logic                pick0;
  logic                fire;
  logic                win_we;
  logic [2:0]          win_id;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  tag_t                tag1;
  tag_t                tag2;

  assign others = |bus.req_valid[NUM_REQ-1:1];
  assign pick0  = bus.req_valid[0] &
                  ((consec_cnt < MAXC) | ~others);

  rr_select #(.N(NUM_REQ)) u_rr (
    .valid (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (rr_grant)
  );

  assign grant         = pick0 ? NUM_REQ'(1) : rr_grant;
  assign fire          = |grant;
  assign bus.req_ready = grant;

  // Mux the winner's fields and compute the next rr pointer.
  always_comb begin
    win_we    = 1'b0;
    win_id    = '0;
    win_addr  = '0;
    win_wdata = '0;
    ptr_nxt   = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_we    = bus.req_we[i];
        win_id    = 3'(i);
        win_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        win_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
        if (i != 0) begin
          ptr_nxt = (i == NUM_REQ - 1) ? 3'd1 : 3'(i + 1);
        end
      end
    end
  end

  // Starvation counter for requester 0 and rr pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      consec_cnt <= '0;
      rr_ptr     <= 3'd1;
    end else begin
      rr_ptr <= ptr_nxt;
      if (!bus.req_valid[0]) begin
        consec_cnt <= '0;
      end else if (|grant[NUM_REQ-1:1]) begin
        consec_cnt <= '0;
      end else if (grant[0] && others &&
                   consec_cnt < MAXC) begin
        consec_cnt <= consec_cnt + 1'b1;
      end
    end
  end

  // RAM port registers and the 2-stage read tag pipe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      tag1      <= '0;
      tag2      <= '0;
    end else begin
      ram_cs <= fire;
      ram_we <= fire & win_we;
      if (fire) begin
        ram_addr  <= win_addr;
        ram_wdata <= win_wdata;
      end
      tag1 <= '{rd: fire & ~win_we, id: win_id};
      tag2 <= tag1;
    end
  end

  // Decode the stage-2 tag into a one-hot response pulse.
  always_comb begin
    rsp = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag2.rd && tag2.id == 3'(i)) begin
        rsp[i] = 1'b1;
      end
    end
  end

  assign bus.rsp_valid = rsp;
  assign bus.rsp_rdata = ram_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: grant tables, hand sequences
// and a response scoreboard against a behavioural RAM.
`timescale 1ns/1ps
module tb_vram_arbiter;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ram_cs;
  logic       ram_we;
  logic [13:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  vram_arbiter_if #(.NUM_REQ(3), .ADDR_W(14), .DATA_W(8)) bus();

  vram_arbiter #(
    .NUM_REQ(3), .ADDR_W(14), .DATA_W(8), .MAX_CONSEC(4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input logic [13:0] a);
    if (a == 14'h0123) return 8'hA5;
    return a[7:0] ^ {2'b00, a[13:8]};
  endfunction

  // Behavioural RAM: write and registered read at the edge
  // where the registered port signals are presented.
  logic [7:0] mem [int];
  always @(posedge clock) begin
    if (ram_cs) begin
      if (ram_we) begin
        mem[int'(ram_addr)] = ram_wdata;
      end else begin
        ram_rdata <= mem.exists(int'(ram_addr)) ?
                     mem[int'(ram_addr)] : init_val(ram_addr);
      end
    end
  end

  // Reference memory contents as seen by accepted requests.
  logic [7:0] ref_wr [int];
  function automatic logic [7:0] ref_rd(input logic [13:0] a);
    if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
    return init_val(a);
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               name, got, exp, $time);
    end
  endtask

  typedef struct {
    int         id;
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t sbq[$];

  // Scoreboard: push on accepted reads, pop on responses.
  always @(negedge clock) begin
    exp_t e;
    logic [13:0] a;
    if (!reset_n) begin
      sbq.delete();
    end else begin
      chk("grant_onehot",
          32'($countones(bus.req_ready) <= 1), 32'd1);
      chk("grant_valid",
          32'(bus.req_ready & ~bus.req_valid), 32'd0);
      if (bus.rsp_valid != 3'b000) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_id", 32'(bus.rsp_valid),
              32'(3'b001 << e.id));
          chk("rsp_data", 32'(bus.rsp_rdata), 32'(e.data));
          chk("rsp_latency", 32'(cyc), 32'(e.due));
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        chk("rsp_missing", 32'(bus.rsp_valid),
            32'(3'b001 << e.id));
      end
      for (int i = 0; i < 3; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          a = bus.req_addr[i*14 +: 14];
          if (bus.req_we[i]) begin
            ref_wr[int'(a)] = bus.req_wdata[i*8 +: 8];
          end else begin
            e.id   = i;
            e.data = ref_rd(a);
            e.due  = cyc + 2;
            sbq.push_back(e);
          end
        end
      end
    end
  end

  task automatic cyc1();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [2:0] v,
                       input logic [2:0] w,
                       input logic [13:0] a0,
                       input logic [13:0] a1,
                       input logic [13:0] a2,
                       input logic [7:0] d);
    bus.req_valid = v;
    bus.req_we    = w;
    bus.req_addr  = {a2, a1, a0};
    bus.req_wdata = {d, d, d};
  endtask

  task automatic do_reset();
    drive(3'b000, 3'b000, 14'h0, 14'h0, 14'h0, 8'h0);
    repeat (4) @(posedge clock);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0] valid;
    logic [2:0] exp_ready;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs[NV];
  int   cnt[3];
  int   stale;

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{
      '{3'b111, 3'b001}, '{3'b111, 3'b001},
      '{3'b111, 3'b001}, '{3'b111, 3'b001},
      '{3'b111, 3'b010}, '{3'b111, 3'b001},
      '{3'b111, 3'b001}, '{3'b111, 3'b001},
      '{3'b111, 3'b001}, '{3'b111, 3'b100},
      '{3'b111, 3'b001}, '{3'b000, 3'b000},
      '{3'b110, 3'b010}, '{3'b110, 3'b100},
      '{3'b110, 3'b010}, '{3'b110, 3'b100},
      '{3'b110, 3'b010}, '{3'b110, 3'b100},
      '{3'b011, 3'b001}, '{3'b011, 3'b001},
      '{3'b011, 3'b001}, '{3'b001, 3'b001},
      '{3'b011, 3'b001}, '{3'b011, 3'b010},
      '{3'b101, 3'b001}, '{3'b100, 3'b100},
      '{3'b010, 3'b010}, '{3'b110, 3'b100},
      '{3'b000, 3'b000}
    };
    cnt = '{0, 0, 0};

    drive(3'b000, 3'b000, 14'h0, 14'h0, 14'h0, 8'h0);
    @(negedge clock);
    chk("rst_ram_cs", 32'(ram_cs), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Priority, starvation limit and round-robin table.
    for (int k = 0; k < NV; k++) begin
      cyc1();
      drive(vecs[k].valid, 3'b000,
            14'h0400 + 14'(cnt[0]),
            14'h0800 + 14'(cnt[1]),
            14'h1000 + 14'(cnt[2]), 8'h00);
      @(negedge clock);
      chk($sformatf("vec%0d_ready", k),
          32'(bus.req_ready), 32'(vecs[k].exp_ready));
      for (int i = 0; i < 3; i++) begin
        if (vecs[k].exp_ready[i]) cnt[i]++;
      end
    end

    // Single read of a preloaded location.
    do_reset();
    cyc1();
    drive(3'b010, 3'b000, 14'h0, 14'h0123, 14'h0, 8'h0);
    @(negedge clock);
    chk("sr_ready", 32'(bus.req_ready), 32'h2);
    cyc1();
    drive(3'b000, 3'b000, 14'h0, 14'h0, 14'h0, 8'h0);
    @(negedge clock);
    chk("sr_early", 32'(bus.rsp_valid), 32'h0);
    @(negedge clock);
    chk("sr_rsp", 32'(bus.rsp_valid), 32'h2);
    chk("sr_data", 32'(bus.rsp_rdata), 32'hA5);

    // Write by 2 then read of the same address by 1.
    do_reset();
    cyc1();
    drive(3'b100, 3'b100, 14'h0, 14'h0, 14'h3FFF, 8'h5A);
    @(negedge clock);
    chk("wr_ready", 32'(bus.req_ready), 32'h4);
    cyc1();
    drive(3'b010, 3'b000, 14'h0, 14'h3FFF, 14'h0, 8'h0);
    @(negedge clock);
    chk("rd_ready", 32'(bus.req_ready), 32'h2);
    cyc1();
    drive(3'b000, 3'b000, 14'h0, 14'h0, 14'h0, 8'h0);
    @(negedge clock);
    chk("wr_no_rsp", 32'(bus.rsp_valid), 32'h0);
    @(negedge clock);
    chk("wr_rd_rsp", 32'(bus.rsp_valid), 32'h2);
    chk("wr_rd_data", 32'(bus.rsp_rdata), 32'h5A);

    // Back-to-back reads from all three requesters.
    do_reset();
    cyc1();
    drive(3'b111, 3'b000, 14'h0010, 14'h0200, 14'h1004, 8'h0);
    @(negedge clock);
    chk("b2b_g0", 32'(bus.req_ready), 32'h1);
    cyc1();
    drive(3'b110, 3'b000, 14'h0010, 14'h0200, 14'h1004, 8'h0);
    @(negedge clock);
    chk("b2b_g1", 32'(bus.req_ready), 32'h2);
    cyc1();
    drive(3'b100, 3'b000, 14'h0010, 14'h0200, 14'h1004, 8'h0);
    @(negedge clock);
    chk("b2b_g2", 32'(bus.req_ready), 32'h4);
    chk("b2b_r0", 32'(bus.rsp_valid), 32'h1);
    chk("b2b_d0", 32'(bus.rsp_rdata), 32'(ref_rd(14'h0010)));
    cyc1();
    drive(3'b000, 3'b000, 14'h0, 14'h0, 14'h0, 8'h0);
    @(negedge clock);
    chk("b2b_r1", 32'(bus.rsp_valid), 32'h2);
    chk("b2b_d1", 32'(bus.rsp_rdata), 32'(ref_rd(14'h0200)));
    @(negedge clock);
    chk("b2b_r2", 32'(bus.rsp_valid), 32'h4);
    chk("b2b_d2", 32'(bus.rsp_rdata), 32'(ref_rd(14'h1004)));

    // Reset one cycle after a read is accepted.
    do_reset();
    cyc1();
    drive(3'b100, 3'b000, 14'h0, 14'h0, 14'h0155, 8'h0);
    @(negedge clock);
    chk("rm_rd_ready", 32'(bus.req_ready), 32'h4);
    cyc1();
    drive(3'b010, 3'b010, 14'h0, 14'h2222, 14'h0, 8'h77);
    @(negedge clock);
    chk("rm_wr_ready", 32'(bus.req_ready), 32'h2);
    cyc1();
    drive(3'b000, 3'b000, 14'h0, 14'h0, 14'h0, 8'h0);
    chk("rm_pre_we", 32'(ram_we), 32'd1);
    chk("rm_pre_rsp", 32'(bus.rsp_valid), 32'h4);
    reset_n = 1'b0;
    #1;
    chk("rm_cs", 32'(ram_cs), 32'd0);
    chk("rm_we", 32'(ram_we), 32'd0);
    chk("rm_addr", 32'(ram_addr), 32'd0);
    chk("rm_wdata", 32'(ram_wdata), 32'd0);
    chk("rm_rsp", 32'(bus.rsp_valid), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    stale = 0;
    repeat (4) begin
      @(negedge clock);
      if (bus.rsp_valid != 3'b000) stale++;
    end
    chk("rm_stale", 32'(stale), 32'd0);
    cyc1();
    drive(3'b110, 3'b000, 14'h0, 14'h0300, 14'h0301, 8'h0);
    @(negedge clock);
    chk("rm_post_g1", 32'(bus.req_ready), 32'h2);
    cyc1();
    drive(3'b100, 3'b000, 14'h0, 14'h0300, 14'h0301, 8'h0);
    @(negedge clock);
    chk("rm_post_g2", 32'(bus.req_ready), 32'h4);
    cyc1();
    drive(3'b000, 3'b000, 14'h0, 14'h0, 14'h0, 8'h0);
    repeat (4) @(negedge clock);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
